// File: rtl/lvds_tx_framer_pkg.sv
// -----------------------------------------------------------------------------
// lvds_tx_framer_pkg
//   Shared definitions for the LVDS transmit framer: lane geometry, FSM state
//   encodings, the fixed sync preamble bytes and small helper functions.
//   No ports (package).
// -----------------------------------------------------------------------------
package lvds_tx_framer_pkg;

    localparam int LANES  = 8;
    localparam int LANE_W = 8;
    localparam int WORD_W = LANES * LANE_W;

    localparam logic [1:0] ST_BLANK  = 2'd0;
    localparam logic [1:0] ST_SAV    = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_EAV    = 2'd3;

    localparam logic [7:0] SYNC_PRE0 = 8'hFF;
    localparam logic [7:0] SYNC_PRE1 = 8'h00;
    localparam logic [7:0] SYNC_PRE2 = 8'h00;

    // Same byte on every lane, lane-major layout.
    function automatic logic [WORD_W-1:0] fill_lanes(input logic [LANE_W-1:0] b);
        return {LANES{b}};
    endfunction

    // Byte idx of a 4-byte sync sequence FF,00,00,code.
    function automatic logic [7:0] sync_byte(input logic [1:0] idx, input logic [7:0] code);
        logic [7:0] b;
        case (idx)
            2'd0:    b = SYNC_PRE0;
            2'd1:    b = SYNC_PRE1;
            2'd2:    b = SYNC_PRE2;
            default: b = code;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lvds_tx_transpose.sv
// -----------------------------------------------------------------------------
// lvds_tx_transpose
//   Purely combinational lane-major -> OSERDES bit map. Lane k bit b (b=7 is
//   the MSB, first on the wire) lands at serdes_word[8*(7-b)+(7-k)], so each
//   output byte holds one bit-time across all lanes. This is the exact inverse
//   of the receive de-interleave.
// Ports:
//   lane_word   in  64  lane k byte at [8k+7:8k]
//   serdes_word out 64  parallel word for the 8:1 OSERDES bank
// -----------------------------------------------------------------------------
module lvds_tx_transpose
    import lvds_tx_framer_pkg::*;
(
    input  logic [WORD_W-1:0] lane_word,
    output logic [WORD_W-1:0] serdes_word
);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        for (genvar b = 0; b < LANE_W; b++) begin : g_bit
            assign serdes_word[LANES*(LANE_W-1-b) + (LANES-1-k)] = lane_word[LANE_W*k + b];
        end
    end

endmodule

// File: rtl/lvds_tx_framer.sv
// -----------------------------------------------------------------------------
// lvds_tx_framer
//   Wraps each line of 8-lane x 8-bit pixel beats in SAV/EAV sync codes with
//   blanking and emits the bit-transposed OSERDES word every cycle.
//   Optional feature macro: LVDS_TX_TEST_PATTERN_EN (built-in test line,
//   lane k byte = beat_index + k). Without it i_test_mode is ignored.
// Ports:
//   clk          in   1   single clock, also the OSERDES parallel clock
//   rst_n        in   1   synchronous reset, active-low
//   i_data       in   64  pixel beat, lane k at [8k+7:8k]
//   i_valid      in   1   i_data valid
//   o_ready      out  1   beat accepted when i_valid & o_ready
//   i_clear      in   1   clears sticky o_underflow
//   i_test_mode  in   1   test-pattern select
//   o_lvds       out  64  transposed OSERDES word, registered
//   o_busy       out  1   high in SAV/ACTIVE/EAV
//   o_underflow  out  1   sticky: i_valid low during an ACTIVE beat
// -----------------------------------------------------------------------------
// state  | meaning
// BLANK  | emit BLANK_CODE, count gap beats, wait for minimum gap and i_valid
// SAV    | emit FF,00,00,SAV_CODE
// ACTIVE | emit pixel beats (or test pattern) until LINE_BEATS taken
// EAV    | emit FF,00,00,EAV_CODE, then back to BLANK with gap count cleared
// -----------------------------------------------------------------------------
module lvds_tx_framer
    import lvds_tx_framer_pkg::*;
#(
    parameter int         LINE_BEATS   = 240,
    parameter int         HBLANK_BEATS = 16,
    parameter logic [7:0] BLANK_CODE   = 8'h00,
    parameter logic [7:0] SAV_CODE     = 8'hAB,
    parameter logic [7:0] EAV_CODE     = 8'hB6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_clear,
    input  logic              i_test_mode,
    output logic [WORD_W-1:0] o_lvds,
    output logic              o_busy,
    output logic              o_underflow
);

    localparam int BEAT_W  = $clog2(LINE_BEATS + 1);
    localparam int BLANK_W = $clog2(HBLANK_BEATS + 1);
    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(LINE_BEATS - 1);
    localparam logic [BLANK_W-1:0] LAST_BLANK = BLANK_W'(HBLANK_BEATS - 1);

    logic [1:0]         state, state_nxt;
    logic [BEAT_W-1:0]  beat_cnt, beat_nxt;
    logic [BLANK_W-1:0] blank_cnt, blank_nxt;
    logic [1:0]         sync_idx, idx_nxt;
    logic               test_line, test_nxt;
    logic               underflow, uf_set;
    logic               tm_en;
    logic               beat_taken;
    logic [WORD_W-1:0]  pattern_word;
    logic [WORD_W-1:0]  tx_lanes;
    logic [WORD_W-1:0]  lane_word;
    logic [WORD_W-1:0]  serdes_word;

`ifdef LVDS_TX_TEST_PATTERN_EN
    assign tm_en = i_test_mode;
    for (genvar k = 0; k < LANES; k++) begin : g_pattern
        assign pattern_word[LANE_W*k +: LANE_W] = 8'(beat_cnt) + 8'(k);
    end
`else
    logic unused_test_mode;
    assign unused_test_mode = i_test_mode;
    assign tm_en            = 1'b0;
    assign pattern_word     = '0;
`endif

    // A test line advances every cycle regardless of i_valid.
    assign beat_taken = test_line | i_valid;

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        blank_nxt = blank_cnt;
        idx_nxt   = sync_idx;
        test_nxt  = test_line;
        uf_set    = 1'b0;
        tx_lanes  = fill_lanes(BLANK_CODE);
        case (state)
            ST_BLANK: begin
                // blank_cnt = gap beats already sent; this beat completes the
                // minimum gap once blank_cnt reaches HBLANK_BEATS-1.
                if (blank_cnt != LAST_BLANK) begin
                    blank_nxt = blank_cnt + 1'b1;
                end
                if (blank_cnt >= LAST_BLANK && i_valid) begin
                    state_nxt = ST_SAV;
                    idx_nxt   = 2'd0;
                    test_nxt  = tm_en;
                end
            end
            ST_SAV: begin
                tx_lanes = fill_lanes(sync_byte(sync_idx, SAV_CODE));
                idx_nxt  = sync_idx + 2'd1;
                if (sync_idx == 2'd3) begin
                    state_nxt = ST_ACTIVE;
                    beat_nxt  = '0;
                end
            end
            ST_ACTIVE: begin
                if (test_line) begin
                    tx_lanes = pattern_word;
                end else if (i_valid) begin
                    tx_lanes = i_data;
                end else begin
                    uf_set = 1'b1;
                end
                if (beat_taken) begin
                    beat_nxt = beat_cnt + 1'b1;
                    if (beat_cnt == LAST_BEAT) begin
                        state_nxt = ST_EAV;
                        beat_nxt  = '0;
                        idx_nxt   = 2'd0;
                    end
                end
            end
            default: begin
                tx_lanes = fill_lanes(sync_byte(sync_idx, EAV_CODE));
                idx_nxt  = sync_idx + 2'd1;
                if (sync_idx == 2'd3) begin
                    state_nxt = ST_BLANK;
                    blank_nxt = '0;
                    test_nxt  = 1'b0;
                end
            end
        endcase
    end

    // Reset forces the blank word so o_lvds comes out of reset as blanking.
    assign lane_word = rst_n ? tx_lanes : fill_lanes(BLANK_CODE);

    lvds_tx_transpose u_transpose (
        .lane_word   (lane_word),
        .serdes_word (serdes_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_BLANK;
            beat_cnt  <= '0;
            blank_cnt <= '0;
            sync_idx  <= 2'd0;
            test_line <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= beat_nxt;
            blank_cnt <= blank_nxt;
            sync_idx  <= idx_nxt;
            test_line <= test_nxt;
            // Set wins over a same-cycle clear.
            underflow <= uf_set | (underflow & ~i_clear);
        end
    end

    always_ff @(posedge clk) begin
        o_lvds <= serdes_word;
    end

    assign o_ready     = (state == ST_ACTIVE) && !test_line;
    assign o_busy      = (state != ST_BLANK);
    assign o_underflow = underflow;

endmodule

// File: tb/tb_lvds_tx_framer.sv
module tb_lvds_tx_framer;

    localparam int          LB   = 4;
    localparam int          HB   = 2;
    localparam logic [63:0] BASE = 64'h0706050403020100;
    localparam logic [63:0] BLK  = 64'h0;
    localparam logic [63:0] SFF  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] SAB  = 64'hABAB_ABAB_ABAB_ABAB;
    localparam logic [63:0] SB6  = 64'hB6B6_B6B6_B6B6_B6B6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_clear = 1'b0;
    logic        i_test_mode = 1'b0;
    logic [63:0] i_data = BASE;
    logic        o_ready, o_busy, o_underflow;
    logic [63:0] o_lvds;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lvds_tx_framer #(.LINE_BEATS(LB), .HBLANK_BEATS(HB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_clear     (i_clear),
        .i_test_mode (i_test_mode),
        .o_lvds      (o_lvds),
        .o_busy      (o_busy),
        .o_underflow (o_underflow)
    );

    typedef struct {
        logic        r;
        logic        v;
        logic [7:0]  d;
        logic [63:0] lanes;
        logic        rdy;
        logic        busy;
    } vec_t;

    vec_t tbl[24];

    // Receiver-side de-interleave: lane k bit b sits at 8*(7-b)+(7-k).
    function automatic logic [63:0] rx_decode(input logic [63:0] w);
        logic [63:0] lanes;
        lanes = '0;
        for (int k = 0; k < 8; k++)
            for (int b = 0; b < 8; b++)
                lanes[8*k+b] = w[8*(7-b)+(7-k)];
        return lanes;
    endfunction

    function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                                input logic [63:0] lanes, input logic rdy, input logic busy);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.lanes = lanes; t.rdy = rdy; t.busy = busy;
        return t;
    endfunction

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive inputs for one clock, return sampled at the following negedge.
    task automatic cyc(input logic r, input logic v, input logic c, input logic t,
                       input logic [63:0] d);
        rst_n = r; i_valid = v; i_clear = c; i_test_mode = t; i_data = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready(input logic t, input string name);
        int n;
        n = 0;
        while (o_ready !== 1'b1 && n < 30) begin
            cyc(1'b1, 1'b1, 1'b0, t, BASE);
            n++;
        end
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s: o_ready=%b after %0d cycles, expected 1", name, o_ready, n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset (3 cycles), one full line, then back-to-back gap into line 2.
        tbl[0]  = mk(1'b0, 1'b0, 8'd0, BLK, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 8'd0, BLK, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b0, 8'd0, BLK, 1'b0, 1'b0);
        tbl[3]  = mk(1'b1, 1'b1, 8'd0, BLK, 1'b0, 1'b0);
        tbl[4]  = mk(1'b1, 1'b1, 8'd0, BLK, 1'b0, 1'b1);
        tbl[5]  = mk(1'b1, 1'b1, 8'd0, SFF, 1'b0, 1'b1);
        tbl[6]  = mk(1'b1, 1'b1, 8'd0, BLK, 1'b0, 1'b1);
        tbl[7]  = mk(1'b1, 1'b1, 8'd0, BLK, 1'b0, 1'b1);
        tbl[8]  = mk(1'b1, 1'b1, 8'd0, SAB, 1'b1, 1'b1);
        tbl[9]  = mk(1'b1, 1'b1, 8'd0, BASE + 64'd0, 1'b1, 1'b1);
        tbl[10] = mk(1'b1, 1'b1, 8'd1, BASE + 64'd1, 1'b1, 1'b1);
        tbl[11] = mk(1'b1, 1'b1, 8'd2, BASE + 64'd2, 1'b1, 1'b1);
        tbl[12] = mk(1'b1, 1'b1, 8'd3, BASE + 64'd3, 1'b0, 1'b1);
        tbl[13] = mk(1'b1, 1'b1, 8'd4, SFF, 1'b0, 1'b1);
        tbl[14] = mk(1'b1, 1'b1, 8'd4, BLK, 1'b0, 1'b1);
        tbl[15] = mk(1'b1, 1'b1, 8'd4, BLK, 1'b0, 1'b1);
        tbl[16] = mk(1'b1, 1'b1, 8'd4, SB6, 1'b0, 1'b0);
        tbl[17] = mk(1'b1, 1'b1, 8'd4, BLK, 1'b0, 1'b0);
        tbl[18] = mk(1'b1, 1'b1, 8'd4, BLK, 1'b0, 1'b1);
        tbl[19] = mk(1'b1, 1'b1, 8'd4, SFF, 1'b0, 1'b1);
        tbl[20] = mk(1'b1, 1'b1, 8'd4, BLK, 1'b0, 1'b1);
        tbl[21] = mk(1'b1, 1'b1, 8'd4, BLK, 1'b0, 1'b1);
        tbl[22] = mk(1'b1, 1'b1, 8'd4, SAB, 1'b1, 1'b1);
        tbl[23] = mk(1'b1, 1'b1, 8'd4, BASE + 64'd4, 1'b1, 1'b1);

        for (int i = 0; i < 24; i++) begin
            cyc(tbl[i].r, tbl[i].v, 1'b0, 1'b0, BASE + 64'(tbl[i].d));
            chk64($sformatf("vec%0d_lanes", i), rx_decode(o_lvds), tbl[i].lanes);
            chk1($sformatf("vec%0d_ready", i), o_ready, tbl[i].rdy);
            chk1($sformatf("vec%0d_busy", i), o_busy, tbl[i].busy);
            chk1($sformatf("vec%0d_uf", i), o_underflow, 1'b0);
            if (i == 2)  chk64("raw_reset_word", o_lvds, 64'h0);
            if (i == 8)  chk64("raw_sav_word", o_lvds, 64'hFFFF00FF00FF00FF);
            if (i == 9)  chk64("raw_beat0_word", o_lvds, 64'h55330F0000000000);
        end

        // Underflow: one missing beat mid-line, clear, then set beats clear.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, BASE);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, BASE);
        chk1("uf_line_ready", o_ready, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, BASE + 64'd0);
        chk64("uf_beat0", rx_decode(o_lvds), BASE + 64'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, BASE + 64'd1);
        chk64("uf_beat1", rx_decode(o_lvds), BASE + 64'd1);
        chk1("uf_before", o_underflow, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, BASE + 64'd2);
        chk64("uf_gap_blank", rx_decode(o_lvds), BLK);
        chk1("uf_set", o_underflow, 1'b1);
        chk1("uf_ready_held", o_ready, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, BASE + 64'd2);
        chk64("uf_beat2", rx_decode(o_lvds), BASE + 64'd2);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, BASE + 64'd3);
        chk64("uf_beat3", rx_decode(o_lvds), BASE + 64'd3);
        chk1("uf_line_end_ready", o_ready, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, BASE + 64'd4);
        chk64("uf_eav_ff", rx_decode(o_lvds), SFF);
        chk1("uf_cleared", o_underflow, 1'b0);
        wait_ready(1'b0, "uf_next_line");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, BASE);
        chk1("uf_set_beats_clear", o_underflow, 1'b1);
        chk64("uf_set_clear_blank", rx_decode(o_lvds), BLK);

        // Reset in the second ACTIVE beat: no EAV, fresh gap, then SAV.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, BASE);
        chk1("rst_uf_cleared", o_underflow, 1'b0);
        wait_ready(1'b0, "rst_line_ready");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, BASE + 64'd0);
        chk64("rst_beat0", rx_decode(o_lvds), BASE + 64'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, BASE + 64'd1);
        chk64("rst_mid_blank", rx_decode(o_lvds), BLK);
        chk1("rst_mid_busy", o_busy, 1'b0);
        chk1("rst_mid_ready", o_ready, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, BASE + 64'd1);
        chk64("rst_gap1", rx_decode(o_lvds), BLK);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, BASE + 64'd1);
        chk64("rst_gap2", rx_decode(o_lvds), BLK);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, BASE + 64'd1);
        chk64("rst_sav_ff", rx_decode(o_lvds), SFF);

`ifdef LVDS_TX_TEST_PATTERN_EN
        // Test line: ready never rises, pattern lane k = beat + k, no underflow.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, BASE);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b1, BASE);
            chk1($sformatf("tp_ready_pre%0d", i), o_ready, 1'b0);
        end
        chk64("tp_sav_code", rx_decode(o_lvds), SAB);
        for (int n = 0; n < 4; n++) begin
            logic [63:0] lanes;
            logic [7:0]  lane3_exp;
            cyc(1'b1, 1'b0, 1'b0, 1'b1, BASE);
            lanes = rx_decode(o_lvds);
            lane3_exp = 8'(3 + n);
            chk64($sformatf("tp_beat%0d", n), lanes,
                  BASE + 64'(n) * 64'h0101010101010101);
            chk64($sformatf("tp_lane3_%0d", n), {56'h0, lanes[31:24]}, {56'h0, lane3_exp});
            chk1($sformatf("tp_ready%0d", n), o_ready, 1'b0);
            chk1($sformatf("tp_uf%0d", n), o_underflow, 1'b0);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1, BASE);
        chk64("tp_eav_ff", rx_decode(o_lvds), SFF);
`else
        // Without the feature, i_test_mode must not suppress a normal line.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, BASE);
        wait_ready(1'b1, "tm_ignored_ready");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
